inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the combinational instruction ROM.
//  Owns the PC, drives the ROM ce/addr and samples the returned instruction in the
//  same cycle. Registers pc/inst into the IF/ID pipeline register toward decode.
//  Handles stalls, branch redirects (MIPS delay-slot semantics) and exception flushes.
// PARAMETERS
//  ADDR_W    32            PC / ROM address width
//  DATA_W    32            instruction width
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk            in   1       system clock, all state on rising edge
//  rst            in   1       synchronous, active-high reset
//  stall_if       in   1       hold PC (from ctrl)
//  stall_id       in   1       hold IF/ID register (from ctrl)
//  flush          in   1       exception/eret redirect; highest priority
//  new_pc         in   ADDR_W  redirect target used with flush
//  branch_flag    in   1       taken branch/jump resolved in ID
//  branch_target  in   ADDR_W  branch destination
//  rom_ce         out  1       ROM chip enable
//  rom_addr       out  ADDR_W  ROM byte address (= PC)
//  rom_inst       in   DATA_W  ROM data, combinational from rom_addr
//  id_pc          out  ADDR_W  PC of instruction in IF/ID
//  id_inst        out  DATA_W  instruction in IF/ID (0 = NOP bubble)
//  id_valid       out  1       IF/ID holds a real instruction
//  id_adel        out  1       fetch address misaligned (PC[1:0]!=0)
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, rom_ce=0, br_pend=0, id_pc=0, id_inst=0,
//   id_valid=0, id_adel=0. rst overrides everything, including mid-stall/mid-branch.
//  FSM: IDLE -(rst low)-> FETCH; FETCH -(rst)-> IDLE. rom_ce=1 only in FETCH.
//   First fetch at RESET_PC in the first FETCH cycle; pc is not advanced in IDLE.
//  rom_addr = pc always (registered, glitch-free). ROM indexes addr[..:2].
//  Next-PC priority in FETCH:
//   1 flush          -> pc=new_pc; br_pend cleared (flush ignores stall_if)
//   2 stall_if       -> pc held; if branch_flag: br_pend=1, br_tgt=branch_target
//   3 br_pend        -> pc=br_tgt, br_pend=0
//   4 branch_flag    -> pc=branch_target
//   5 otherwise      -> pc=pc+4 (mod 2^ADDR_W, 32'hFFFF_FFFC wraps to 0)
//  Delay slot: instruction fetched in the cycle branch_flag is seen is the delay
//   slot and is captured normally; redirect takes effect on the next fetch.
//  br_pend + new branch_flag on same non-stalled cycle: br_pend wins, new one dropped
//   (ID cannot issue a second branch before the first redirect; assertion in bench).
//  IF/ID register priority:
//   1 flush                  -> id_pc=0, id_inst=0, id_valid=0, id_adel=0
//   2 stall_id               -> hold all id_* outputs
//   3 stall_if & !stall_id   -> bubble: id_inst=0, id_valid=0, id_adel=0, id_pc=0
//   4 else                   -> id_pc=pc, id_valid=rom_ce, id_adel=rom_ce&(pc[1:0]!=0),
//                               id_inst = (misaligned|!rom_ce) ? 0 : rom_inst
//  Latency: instruction at rom_addr in cycle N appears on id_* in cycle N+1.
//  Misaligned PC keeps fetching sequentially (pc+4) until flush; id_adel set on each.
// TESTING
//  1 rst high 3 cycles, release -> rom_ce 0 first cycle, then addr 0,4,8; id_pc 0,4
//    one cycle behind, id_inst = ROM words, id_valid=1.
//  2 branch_flag=1,target=0x40 while pc=0x10 -> id sees 0x10 (delay slot), then 0x40,0x44.
//  3 stall_if=1,stall_id=0 for 2 cycles at pc=0x20 -> rom_addr held 0x20, 2 bubbles
//    (id_valid=0), then id_pc=0x20 resumes; stall_id too -> id_* frozen.
//  4 branch_flag (target 0x80) during stall_if -> pc held; after release next pc=0x80.
//  5 flush, new_pc=0x100 during stall_if with br_pend set -> id cleared, next pc=0x100,
//    pending branch discarded.
//  6 branch target 0x42 -> id_adel=1, id_inst=0; pc=0xFFFF_FFFC advances to 0; rst
//    mid-stall -> all outputs to reset values next edge.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage feeding a combinational instruction ROM.
// Owns the PC, drives the ROM chip enable and address, and captures pc/inst into
// the IF/ID pipeline register. Handles stalls, delay-slot branch redirects and
// exception flushes.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   stall_if         hold the PC
//   stall_id         hold the IF/ID register
//   flush            exception/eret redirect to new_pc (highest priority)
//   new_pc           flush redirect target
//   branch_flag      taken branch/jump resolved in ID
//   branch_target    branch destination
//   rom_ce           ROM chip enable (high only while fetching)
//   rom_addr         ROM byte address (= PC, registered)
//   rom_inst         ROM data, combinational from rom_addr
//   id_pc, id_inst   IF/ID pc and instruction (inst 0 = bubble)
//   id_valid         IF/ID holds a real instruction
//   id_adel          fetch address was misaligned
module inst_fetch #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid,
    output logic              id_adel
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              br_pend;
    logic [ADDR_W-1:0] br_tgt;
    logic              misaligned;

    assign misaligned = (pc[1:0] != 2'b00);
    assign rom_addr   = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            rom_ce   <= 1'b0;
            br_pend  <= 1'b0;
            br_tgt   <= '0;
            id_pc    <= '0;
            id_inst  <= '0;
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
        end else begin
            // PC / fetch control
            case (state)
                IDLE: begin
                    // pc stays at RESET_PC so the first FETCH cycle fetches it
                    state  <= FETCH;
                    rom_ce <= 1'b1;
                end
                FETCH: begin
                    if (flush) begin
                        pc      <= new_pc;
                        br_pend <= 1'b0;
                    end else if (stall_if) begin
                        // Remember a branch resolved while stalled; the held
                        // instruction is still its delay slot.
                        if (branch_flag) begin
                            br_pend <= 1'b1;
                            br_tgt  <= branch_target;
                        end
                    end else if (br_pend) begin
                        pc      <= br_tgt;
                        br_pend <= 1'b0;
                    end else if (branch_flag) begin
                        pc <= branch_target;
                    end else begin
                        pc <= pc + ADDR_W'(4);
                    end
                end
                default: begin
                    state  <= IDLE;
                    rom_ce <= 1'b0;
                end
            endcase

            // IF/ID pipeline register
            if (flush) begin
                id_pc    <= '0;
                id_inst  <= '0;
                id_valid <= 1'b0;
                id_adel  <= 1'b0;
            end else if (stall_id) begin
                id_pc    <= id_pc;
            end else if (stall_if) begin
                id_pc    <= '0;
                id_inst  <= '0;
                id_valid <= 1'b0;
                id_adel  <= 1'b0;
            end else begin
                id_pc    <= pc;
                id_valid <= rom_ce;
                id_adel  <= rom_ce & misaligned;
                id_inst  <= (misaligned | ~rom_ce) ? '0 : rom_inst;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed self-checking bench for inst_fetch. A behavioural ROM
// returns a recognisable word per address; inputs change on the falling edge and
// outputs are checked there, half a cycle after each rising edge.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_adel;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic        tb_pend;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {8'hA5, a[25:2]};
    endfunction

    assign rom_inst = rom_word(rom_addr);

    inst_fetch #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush        (flush),
        .new_pc       (new_pc),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_valid     (id_valid),
        .id_adel      (id_adel)
    );

    // The stimulus must never present a second branch while one is pending.
    always @(posedge clk) begin
        if (rst || flush) tb_pend <= 1'b0;
        else if (stall_if) tb_pend <= tb_pend | branch_flag;
        else tb_pend <= 1'b0;
        assert (rst || flush || stall_if || !(tb_pend && branch_flag))
            else $error("branch issued while a redirect is pending");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic valid, input logic adel);
        chk({tag, ".id_pc"}, id_pc, pc);
        chk({tag, ".id_inst"}, id_inst, inst);
        chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, valid});
        chk({tag, ".id_adel"}, {31'b0, id_adel}, {31'b0, adel});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rom_ce"}, {31'b0, rom_ce}, 32'd0);
        chk({tag, ".rom_addr"}, rom_addr, 32'h0);
        chk_id(tag, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0;
        new_pc = '0; branch_flag = 1'b0; branch_target = '0;

        // 1: reset and sequential fetch
        repeat (3) step();
        chk_reset("reset");
        rst = 1'b0;
        step();
        chk("idle.rom_ce", {31'b0, rom_ce}, 32'd1);
        chk("idle.rom_addr", rom_addr, 32'h0);
        chk("idle.id_valid", {31'b0, id_valid}, 32'd0);
        step();
        chk("seq0.rom_addr", rom_addr, 32'h4);
        chk_id("seq0", 32'h0, 32'hA500_0000, 1'b1, 1'b0);
        step();
        chk("seq1.rom_addr", rom_addr, 32'h8);
        chk_id("seq1", 32'h4, 32'hA500_0001, 1'b1, 1'b0);
        step(); step();
        chk("seq3.rom_addr", rom_addr, 32'h10);

        // 2: branch with delay slot
        branch_flag = 1'b1; branch_target = 32'h40;
        step();
        branch_flag = 1'b0;
        chk("br.rom_addr", rom_addr, 32'h40);
        chk_id("br.slot", 32'h10, 32'hA500_0004, 1'b1, 1'b0);
        step();
        chk("br1.rom_addr", rom_addr, 32'h44);
        chk_id("br1", 32'h40, 32'hA500_0010, 1'b1, 1'b0);
        step();
        chk("br2.rom_addr", rom_addr, 32'h48);
        chk("br2.id_pc", id_pc, 32'h44);

        // 3: stall_if bubbles, then stall_id freeze
        branch_flag = 1'b1; branch_target = 32'h20;
        step();
        branch_flag = 1'b0;
        chk("to20.rom_addr", rom_addr, 32'h20);
        stall_if = 1'b1;
        step();
        chk("stl0.rom_addr", rom_addr, 32'h20);
        chk_id("stl0", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk("stl1.rom_addr", rom_addr, 32'h20);
        chk_id("stl1", 32'h0, 32'h0, 1'b0, 1'b0);
        stall_if = 1'b0;
        step();
        chk("stlx.rom_addr", rom_addr, 32'h24);
        chk_id("stlx", 32'h20, 32'hA500_0008, 1'b1, 1'b0);
        stall_if = 1'b1; stall_id = 1'b1;
        repeat (2) step();
        chk("frz.rom_addr", rom_addr, 32'h24);
        chk_id("frz", 32'h20, 32'hA500_0008, 1'b1, 1'b0);
        stall_if = 1'b0; stall_id = 1'b0;
        step();
        chk("frzx.rom_addr", rom_addr, 32'h28);
        chk("frzx.id_pc", id_pc, 32'h24);

        // 4: branch during stall_if becomes pending
        stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h80;
        step();
        branch_flag = 1'b0;
        chk("pend0.rom_addr", rom_addr, 32'h28);
        step();
        chk("pend1.rom_addr", rom_addr, 32'h28);
        stall_if = 1'b0;
        step();
        chk("pendx.rom_addr", rom_addr, 32'h80);
        chk_id("pendx.slot", 32'h28, 32'hA500_000A, 1'b1, 1'b0);
        step();
        chk("pend2.rom_addr", rom_addr, 32'h84);
        chk("pend2.id_pc", id_pc, 32'h80);

        // 5: flush overrides stall and discards pending branch
        stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
        step();
        branch_flag = 1'b0; flush = 1'b1; new_pc = 32'h100;
        step();
        flush = 1'b0; stall_if = 1'b0;
        chk("fl.rom_addr", rom_addr, 32'h100);
        chk_id("fl", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk("fl1.rom_addr", rom_addr, 32'h104);
        chk_id("fl1", 32'h100, 32'hA500_0040, 1'b1, 1'b0);

        // 6: misaligned fetch, wrap-around, reset mid-stall
        branch_flag = 1'b1; branch_target = 32'h42;
        step();
        branch_flag = 1'b0;
        chk("mis.rom_addr", rom_addr, 32'h42);
        step();
        chk("mis1.rom_addr", rom_addr, 32'h46);
        chk_id("mis1", 32'h42, 32'h0, 1'b1, 1'b1);
        branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        branch_flag = 1'b0;
        chk("wrp.rom_addr", rom_addr, 32'hFFFF_FFFC);
        chk_id("wrp", 32'h46, 32'h0, 1'b1, 1'b1);
        step();
        chk("wrp1.rom_addr", rom_addr, 32'h0);
        chk_id("wrp1", 32'hFFFF_FFFC, 32'hA5FF_FFFF, 1'b1, 1'b0);
        stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h300;
        step();
        branch_flag = 1'b0; rst = 1'b1;
        step();
        chk_reset("rst_mid");
        rst = 1'b0; stall_if = 1'b0;
        step();
        chk("rst1.rom_ce", {31'b0, rom_ce}, 32'd1);
        chk("rst1.rom_addr", rom_addr, 32'h0);
        step();
        chk("rst2.rom_addr", rom_addr, 32'h4);
        chk_id("rst2", 32'h0, 32'hA500_0000, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
